// File: rtl/lut_gate_seq.sv
// lut_gate_seq -- reprogrammable N_IN-input truth-table gate.
//
// The truth table is shifted in serially into a shadow register and is
// copied into the active table in one COMMIT cycle, so lookups never see a
// half-loaded table. Input vectors flow through a one-deep valid/ready stage
// with a registered output.
//
// Optional feature: define LUT_GATE_STATS_EN to add the ones_cnt port. It is
// a saturating count of output handshakes that carried out_bit = 1, and it
// is cleared on cfg_done.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   cfg_start          pulse: begin (or restart) a table load
//   cfg_valid/cfg_bit  serial table bits, row 0...0 (table MSB) first
//   cfg_busy           load in progress
//   cfg_done           one-cycle pulse: the new table is now active
//   in_valid/in_ready  input vector handshake, in_vec[N_IN-1] is in1
//   out_valid/out_ready/out_bit  registered result handshake
//   ones_cnt [15:0]    (LUT_GATE_STATS_EN only) ones-output counter
module lut_gate_seq #(
    parameter int                  N_IN       = 3,
    parameter logic [2**N_IN-1:0]  INIT_TABLE = 8'h82
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit
`ifdef LUT_GATE_STATS_EN
    ,
    output logic [15:0]     ones_cnt
`endif
);

    localparam int T  = 2**N_IN;
    localparam int CW = $clog2(T) + 1;
    localparam logic [CW-1:0] LAST = CW'(T - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [T-1:0]  shadow;
    logic [T-1:0]  active;
    logic          accept;

    assign cfg_busy = (state == LOAD);

    // Config FSM. cfg_start inside LOAD only rewinds the count; the shadow
    // is not cleared because a full load of T bits overwrites it anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shadow   <= '0;
            active   <= INIT_TABLE;
            cfg_done <= 1'b0;
        end else begin
            // Registered so the pulse lines up with the new table being live.
            cfg_done <= (state == COMMIT);
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        cnt <= '0;
                    end else if (cfg_valid) begin
                        shadow <= {shadow[T-2:0], cfg_bit};
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= COMMIT;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                COMMIT: begin
                    active <= shadow;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Eval stage. Row idx lives at table bit T-1-idx, which is simply the
    // bitwise inverse of idx over N_IN bits.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_bit   <= active[~in_vec];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LUT_GATE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
        end else if (cfg_done) begin
            ones_cnt <= '0;
        end else if (out_valid && out_ready && out_bit && ones_cnt != 16'hFFFF) begin
            ones_cnt <= ones_cnt + 16'd1;
        end
    end
`endif

endmodule
